// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for the 5-stage MIPS pipeline. It produces the stall,
//   flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline
//   registers. It also sequences the multi-cycle mult/div unit (MDU) through a
//   small IDLE/BUSY FSM, and it keeps a saturating count of stalled cycles for
//   performance monitoring.
//
// Parameters
//   MDU_LAT  cycles the MDU stays occupied after issue from E (1..15)
//   CNT_W    width of the saturating stall-cycle counter
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   RsD, RtD                source registers of the instruction in D
//   RsE, RtE                source registers of the instruction in E
//   WriteRegE/M/W           destination register in E / M / W
//   RegWriteE/M/W           destination write enable in E / M / W
//   MemtoRegE/M             load instruction in E / M
//   BranchD, PCSrcD         branch in D, branch taken (resolved in D)
//   MdOpD                   D instruction uses the MDU
//   MdStartE                mult/div issuing from E this cycle
//   StallF, StallD          hold the PC and the F/D register
//   FlushD, FlushE          clear F/D (taken branch), clear D/E (bubble)
//   ForwardAE/BE            ALU operand select: 00 regfile, 01 W, 10 M
//   ForwardAD/BD            D-stage comparator operand from M
//   MdBusy                  MDU FSM is in BUSY
//   StallCount              saturating count of cycles with StallD=1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MdOpD,
  input  logic             MdStartE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MDU_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall;

  // r0 is hard-wired to zero, so a dependency on it is never a real hazard.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Hazard detection and forwarding selects. M is checked before W so the
  // youngest producer wins. During reset everything is parked in a safe
  // state: no stall, no branch flush, and a bubble into D/E.
  always_comb begin
    lwstall   = MemtoRegE & (reg_match(RtE, RsD) | reg_match(RtE, RtD));
    brstall   = BranchD &
                ((RegWriteE & (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD))) |
                 (MemtoRegM & (reg_match(WriteRegM, RsD) | reg_match(WriteRegM, RtD))));
    mdstall   = MdOpD & ((state_q == BUSY) | MdStartE);
    stall     = lwstall | brstall | mdstall;

    ForwardAE = 2'b00;
    if (RegWriteM && reg_match(RsE, WriteRegM)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && reg_match(RsE, WriteRegW)) begin
      ForwardAE = 2'b01;
    end

    ForwardBE = 2'b00;
    if (RegWriteM && reg_match(RtE, WriteRegM)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && reg_match(RtE, WriteRegW)) begin
      ForwardBE = 2'b01;
    end

    ForwardAD = RegWriteM & reg_match(RsD, WriteRegM);
    ForwardBD = RegWriteM & reg_match(RtD, WriteRegM);

    StallF    = stall;
    StallD    = stall;
    FlushE    = stall;
    FlushD    = PCSrcD & ~stall;

    if (reset) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
    end
  end

  // MDU occupancy FSM. cnt holds the number of BUSY cycles still to come
  // after the current one, so loading MDU_LAT-1 gives exactly MDU_LAT busy
  // cycles. A start while already busy (normally prevented by mdstall)
  // simply restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MdStartE) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
        end
      end
      BUSY: begin
        if (MdStartE) begin
          cnt_d = LAT_M1;
        end else if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Stall-cycle counter: a cycle stalled for several reasons at once still
  // counts once, and the count sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallD && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MdBusy     = (state_q == BUSY);
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed testbench for hazard_ctrl. Combinational hazard/forwarding cases
//   come from a table of vectors; the multi-cycle behaviour (load-use count,
//   MDU busy window, reset mid-BUSY, counter saturation) uses hand-written
//   sequences. The DUT is built with CNT_W=4 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  logic             clk;
  logic             reset;
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, MemtoRegM;
  logic             BranchD, PCSrcD, MdOpD, MdStartE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD;
  logic             MdBusy;
  logic [CNT_W-1:0] StallCount;

  int checks;
  int failures;
  int assertFails;

  typedef struct {
    string      name;
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, m2rE, m2rM, brD, pcSrc, mdOp;
    logic       expStall, expFlushD;
    logic [1:0] expFAE, expFBE;
    logic       expFAD, expFBD;
  } vec_t;

  vec_t vecs[$];

  hazard_ctrl #(
    .MDU_LAT(MDU_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemtoRegE (MemtoRegE),
    .MemtoRegM (MemtoRegM),
    .BranchD   (BranchD),
    .PCSrcD    (PCSrcD),
    .MdOpD     (MdOpD),
    .MdStartE  (MdStartE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .MdBusy    (MdBusy),
    .StallCount(StallCount)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // An MDU issue while the unit is already busy should never be generated.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(MdStartE && MdBusy))
      else begin
        $display("[TB] FAIL mdStartWhileBusy actual=1 expected=0");
        assertFails++;
      end
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mkVec(
    input string name,
    input logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW,
    input logic rwE, rwM, rwW, m2rE, m2rM, brD, pcSrc, mdOp,
    input logic expStall, expFlushD,
    input logic [1:0] expFAE, expFBE,
    input logic expFAD, expFBD);
    vec_t v;
    v.name = name;
    v.rsD = rsD; v.rtD = rtD; v.rsE = rsE; v.rtE = rtE;
    v.wrE = wrE; v.wrM = wrM; v.wrW = wrW;
    v.rwE = rwE; v.rwM = rwM; v.rwW = rwW;
    v.m2rE = m2rE; v.m2rM = m2rM;
    v.brD = brD; v.pcSrc = pcSrc; v.mdOp = mdOp;
    v.expStall = expStall; v.expFlushD = expFlushD;
    v.expFAE = expFAE; v.expFBE = expFBE;
    v.expFAD = expFAD; v.expFBD = expFBD;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; PCSrcD = 1'b0; MdOpD = 1'b0; MdStartE = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    RsD = v.rsD; RtD = v.rtD; RsE = v.rsE; RtE = v.rtE;
    WriteRegE = v.wrE; WriteRegM = v.wrM; WriteRegW = v.wrW;
    RegWriteE = v.rwE; RegWriteM = v.rwM; RegWriteW = v.rwW;
    MemtoRegE = v.m2rE; MemtoRegM = v.m2rM;
    BranchD = v.brD; PCSrcD = v.pcSrc; MdOpD = v.mdOp;
    MdStartE = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal({v.name, ".StallF"},    32'(StallF),    32'(v.expStall));
    checkVal({v.name, ".StallD"},    32'(StallD),    32'(v.expStall));
    checkVal({v.name, ".FlushE"},    32'(FlushE),    32'(v.expStall));
    checkVal({v.name, ".FlushD"},    32'(FlushD),    32'(v.expFlushD));
    checkVal({v.name, ".ForwardAE"}, 32'(ForwardAE), 32'(v.expFAE));
    checkVal({v.name, ".ForwardBE"}, 32'(ForwardBE), 32'(v.expFBE));
    checkVal({v.name, ".ForwardAD"}, 32'(ForwardAD), 32'(v.expFAD));
    checkVal({v.name, ".ForwardBD"}, 32'(ForwardBD), 32'(v.expFBD));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    clearInputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vec_t rstVec;
    checks      = 0;
    failures    = 0;
    assertFails = 0;
    reset       = 1'b1;
    clearInputs();

    //                 name         rsD rtD rsE rtE wrE wrM wrW rwE rwM rwW m2E m2M brD pcS mdO  stl fD  fAE    fBE    fAD fBD
    vecs.push_back(mkVec("fwdM",     0,  0,  3,  0,  0,  3,  3,  0,  1,  1,  0,  0,  0,  0,  0,   0, 0, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mkVec("fwdW",     0,  0,  3,  0,  0,  3,  3,  0,  0,  1,  0,  0,  0,  0,  0,   0, 0, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mkVec("fwdR0",    0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  0,  0,  0,  0,  0,   0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("fwdB",     0,  0,  4,  9,  0,  4,  9,  0,  1,  1,  0,  0,  0,  0,  0,   0, 0, 2'b10, 2'b01, 0, 0));
    vecs.push_back(mkVec("fwdMprio", 0,  0,  4,  4,  0,  4,  4,  0,  1,  1,  0,  0,  0,  0,  0,   0, 0, 2'b10, 2'b10, 0, 0));
    vecs.push_back(mkVec("fwdD",     6,  8,  0,  0,  0,  8,  0,  0,  1,  0,  0,  0,  0,  0,  0,   0, 0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mkVec("fwdDboth", 6,  6,  0,  0,  0,  6,  0,  0,  1,  0,  0,  0,  0,  0,  0,   0, 0, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mkVec("lwRs",     5,  0,  0,  5,  5,  0,  0,  1,  0,  0,  1,  0,  0,  0,  0,   1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("lwRt",     2,  5,  0,  5,  5,  0,  0,  1,  0,  0,  1,  0,  0,  0,  0,   1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("lwR0",     0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  1,  0,  0,  0,  0,   0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("noLoad",   5,  0,  0,  5,  5,  0,  0,  1,  0,  0,  0,  0,  0,  0,  0,   0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("brE",      1,  7,  0,  0,  7,  0,  0,  1,  0,  0,  0,  0,  1,  0,  0,   1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("brEnoWr",  1,  7,  0,  0,  7,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,   0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("brM",      4,  0,  0,  0,  0,  4,  0,  0,  1,  0,  0,  1,  1,  0,  0,   1, 0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mkVec("noBrM",    4,  0,  0,  0,  0,  4,  0,  0,  1,  0,  0,  1,  0,  0,  0,   0, 0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mkVec("brAluM",   4,  0,  0,  0,  0,  4,  0,  0,  1,  0,  0,  0,  1,  0,  0,   0, 0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mkVec("taken",    1,  2,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  0,   0, 1, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("takenStl", 1,  7,  0,  0,  7,  0,  0,  1,  0,  0,  0,  0,  1,  1,  0,   1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("mdIdle",   0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,   0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mkVec("lwTaken",  5,  0,  0,  5,  5,  0,  0,  1,  0,  0,  1,  0,  0,  1,  0,   1, 0, 2'b00, 2'b00, 0, 0));

    // Reset overrides: every hazard and forward condition present at once.
    rstVec = mkVec("rst",            5,  0,  3,  5,  0,  5,  3,  0,  1,  1,  1,  0,  0,  1,  0,   0, 0, 2'b00, 2'b00, 0, 0);
    #2;
    applyStimulus(rstVec);
    #1;
    checkVal("rst.StallF",     32'(StallF),     32'd0);
    checkVal("rst.StallD",     32'(StallD),     32'd0);
    checkVal("rst.FlushD",     32'(FlushD),     32'd0);
    checkVal("rst.FlushE",     32'(FlushE),     32'd1);
    checkVal("rst.ForwardAE",  32'(ForwardAE),  32'd0);
    checkVal("rst.ForwardBE",  32'(ForwardBE),  32'd0);
    checkVal("rst.ForwardAD",  32'(ForwardAD),  32'd0);
    checkVal("rst.ForwardBD",  32'(ForwardBD),  32'd0);
    checkVal("rst.MdBusy",     32'(MdBusy),     32'd0);
    checkVal("rst.StallCount", 32'(StallCount), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clearInputs();

    $display("[TB] table vectors: %0d", vecs.size());
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i]);
    end

    // Load-use: one stall cycle, counted once, then no stall via r0.
    doReset();
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    #1;
    checkVal("lu.StallD",      32'(StallD),     32'd1);
    checkVal("lu.cntBefore",   32'(StallCount), 32'd0);
    @(negedge clk);
    RtE = 5'd0; RsD = 5'd0;
    #1;
    checkVal("lu.r0StallD",    32'(StallD),     32'd0);
    checkVal("lu.cntAfter",    32'(StallCount), 32'd1);
    @(negedge clk);
    #1;
    checkVal("lu.cntHeld",     32'(StallCount), 32'd1);
    clearInputs();

    // MDU: issue in cycle t, busy t+1..t+4, D stalled t..t+4.
    doReset();
    MdOpD = 1'b1; MdStartE = 1'b1;
    #1;
    checkVal("mdu.issueStall", 32'(StallD),     32'd1);
    checkVal("mdu.issueBusy",  32'(MdBusy),     32'd0);
    @(negedge clk);
    MdStartE = 1'b0;
    for (int i = 1; i <= MDU_LAT; i++) begin
      #1;
      checkVal($sformatf("mdu.busy%0d", i),  32'(MdBusy), 32'd1);
      checkVal($sformatf("mdu.stall%0d", i), 32'(StallD), 32'd1);
      @(negedge clk);
    end
    #1;
    checkVal("mdu.doneBusy",   32'(MdBusy),     32'd0);
    checkVal("mdu.doneStall",  32'(StallD),     32'd0);
    checkVal("mdu.count",      32'(StallCount), 32'd5);
    clearInputs();

    // MDU without a dependent D instruction: busy but no stall.
    doReset();
    MdStartE = 1'b1;
    #1;
    checkVal("mdNoOp.stall",   32'(StallD),     32'd0);
    @(negedge clk);
    MdStartE = 1'b0;
    #1;
    checkVal("mdNoOp.busy",    32'(MdBusy),     32'd1);
    checkVal("mdNoOp.stall2",  32'(StallD),     32'd0);
    repeat (MDU_LAT) @(negedge clk);
    #1;
    checkVal("mdNoOp.idle",    32'(MdBusy),     32'd0);
    clearInputs();

    // Reset two cycles after issue, while BUSY.
    doReset();
    MdOpD = 1'b1; MdStartE = 1'b1;
    @(negedge clk);
    MdStartE = 1'b0;
    @(negedge clk);
    #1;
    checkVal("rb.busyPre",     32'(MdBusy),     32'd1);
    checkVal("rb.cntPre",      32'(StallCount), 32'd2);
    reset = 1'b1;
    #1;
    checkVal("rb.busy",        32'(MdBusy),     32'd0);
    checkVal("rb.cnt",         32'(StallCount), 32'd0);
    checkVal("rb.FlushE",      32'(FlushE),     32'd1);
    checkVal("rb.StallD",      32'(StallD),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("rb.relBusy",     32'(MdBusy),     32'd0);
    checkVal("rb.relStall",    32'(StallD),     32'd0);
    @(negedge clk);
    #1;
    checkVal("rb.relBusy2",    32'(MdBusy),     32'd0);
    checkVal("rb.relCnt",      32'(StallCount), 32'd0);
    clearInputs();

    // Saturation: 20 stalled cycles on a 4-bit counter.
    doReset();
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      checkVal($sformatf("sat.cnt%0d", k), 32'(StallCount), (k > 15) ? 32'd15 : 32'(k));
    end
    clearInputs();

    @(negedge clk);
    failures += assertFails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
